// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant derived combinationally from the request
// vector and a registered priority pointer. The pointer moves past the winner
// only when the consumer reports that the grant was used (update_i).
module round_robin_arbiter #(
  parameter int unsigned N_OF_INPUTS = 4
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   update_i,
  input  logic [N_OF_INPUTS-1:0] req_i,
  output logic [N_OF_INPUTS-1:0] grant_o
);

  localparam int unsigned PTR_W = (N_OF_INPUTS > 1) ? $clog2(N_OF_INPUTS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_OF_INPUTS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       ptr_d;
  logic [N_OF_INPUTS-1:0] prio_mask;
  logic [N_OF_INPUTS-1:0] req_masked;
  logic [N_OF_INPUTS-1:0] grant_masked;
  logic [N_OF_INPUTS-1:0] grant_unmasked;
  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_any;

  // Keep only the lowest set bit of a vector (fixed-priority pick, index 0 first).
  function automatic logic [N_OF_INPUTS-1:0] lowest_set(input logic [N_OF_INPUTS-1:0] v);
    logic [N_OF_INPUTS-1:0] r;
    logic                   found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_OF_INPUTS; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Two-pass priority: requests at or above the pointer first, then wrap to the lowest.
  always_comb begin
    prio_mask = '0;
    for (int unsigned i = 0; i < N_OF_INPUTS; i++) begin
      prio_mask[i] = (PTR_W'(i) >= ptr_q);
    end
    req_masked     = req_i & prio_mask;
    grant_masked   = lowest_set(req_masked);
    grant_unmasked = lowest_set(req_i);
    grant_o        = (|req_masked) ? grant_masked : grant_unmasked;
  end

  // Encode the one-hot grant into an index for the pointer update.
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_OF_INPUTS; i++) begin
      if (grant_o[i]) begin
        grant_idx = grant_idx | PTR_W'(i);
      end
    end
    grant_any = |grant_o;
  end

  // Next pointer: winner becomes lowest priority, wrapping from the last index to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (update_i && grant_any) begin
      ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_ONE;
    end
  end

  // Priority pointer register; reset wins over any update at the same edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter (N=4): stimulus pushes hand-computed
// grants into a scoreboard queue; a monitor pops and compares on each falling edge.
module tb_round_robin_arbiter;

  localparam int unsigned N = 4;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] exp;
    string        name;
  } sb_entry_t;

  logic         clk;
  logic         arst;
  logic         update_i;
  logic [N-1:0] req_i;
  logic [N-1:0] grant_o;

  sb_entry_t sb_q[$];
  int tests_run;
  int tests_failed;

  round_robin_arbiter #(.N_OF_INPUTS(N)) dut (
    .clk      (clk),
    .arst     (arst),
    .update_i (update_i),
    .req_i    (req_i),
    .grant_o  (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the grant is sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      sb_entry_t e;
      e = sb_q.pop_front();
      tests_run++;
      if (grant_o !== e.exp) begin
        tests_failed++;
        $display("FAIL %s: req=%b grant=%b expected=%b", e.name, e.req, grant_o, e.exp);
      end
      tests_run++;
      if (((grant_o & ~e.req) != '0) || ($countones(grant_o) > 1)) begin
        tests_failed++;
        $display("FAIL %s_onehot: req=%b grant=%b expected one-hot subset of req",
                 e.name, e.req, grant_o);
      end
    end
  end

  // Drive one cycle of inputs (just after a rising edge) and queue the expected grant.
  task automatic step(input logic [N-1:0] req, input logic upd,
                      input logic [N-1:0] exp, input string name);
    sb_entry_t e;
    req_i    = req;
    update_i = upd;
    e.req    = req;
    e.exp    = exp;
    e.name   = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    arst     = 1'b1;
    update_i = 1'b0;
    req_i    = '0;
    repeat (cycles) @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    arst         = 1'b1;
    update_i     = 1'b0;
    req_i        = '0;
    repeat (10) @(posedge clk);
    #1;

    // Grant follows req during reset with ptr=0; update under reset is ignored.
    step(4'b1111, 1'b1, 4'b0001, "in_reset");
    step(4'b1111, 1'b1, 4'b0001, "in_reset_hold");
    arst = 1'b0;

    // Full rotation with wrap 3->0.
    step(4'b1111, 1'b1, 4'b0001, "rot0");
    step(4'b1111, 1'b1, 4'b0010, "rot1");
    step(4'b1111, 1'b1, 4'b0100, "rot2");
    step(4'b1111, 1'b1, 4'b1000, "rot3");
    step(4'b1111, 1'b1, 4'b0001, "rot_wrap");

    // Alternating pair 1010.
    do_reset(2);
    step(4'b1010, 1'b1, 4'b0010, "alt0");
    step(4'b1010, 1'b1, 4'b1000, "alt1");
    step(4'b1010, 1'b1, 4'b0010, "alt2");
    step(4'b1010, 1'b1, 4'b1000, "alt3");

    // 1011: index 2 skipped.
    do_reset(2);
    step(4'b1011, 1'b1, 4'b0001, "skip0");
    step(4'b1011, 1'b1, 4'b0010, "skip1");
    step(4'b1011, 1'b1, 4'b1000, "skip2");
    step(4'b1011, 1'b1, 4'b0001, "skip3");

    // Single requesters, then holds with update_i low (ptr ends at 3).
    do_reset(2);
    step(4'b0001, 1'b1, 4'b0001, "single0");
    step(4'b0010, 1'b1, 4'b0010, "single1");
    step(4'b0100, 1'b1, 4'b0100, "single2");
    step(4'b1000, 1'b1, 4'b1000, "single3");
    step(4'b0100, 1'b1, 4'b0100, "single2_again");
    step(4'b1111, 1'b0, 4'b1000, "hold_ptr3");
    step(4'b0011, 1'b0, 4'b0001, "hold_wrap");
    step(4'b1111, 1'b0, 4'b1000, "hold_ptr3_again");

    // No requests with updates: ptr stays 3.
    step(4'b0000, 1'b1, 4'b0000, "zero0");
    step(4'b0000, 1'b1, 4'b0000, "zero1");
    step(4'b0000, 1'b1, 4'b0000, "zero2");
    step(4'b1111, 1'b0, 4'b1000, "after_zero");
    // Update with a freshly changed request: winner 1 moves ptr to 2.
    step(4'b0110, 1'b1, 4'b0010, "upd_new_req");
    step(4'b1111, 1'b0, 4'b0100, "after_upd_new_req");

    // Mid-run asynchronous reset with ptr=2.
    do_reset(2);
    step(4'b1111, 1'b1, 4'b0001, "mid0");
    step(4'b1111, 1'b1, 4'b0010, "mid1");
    step(4'b1111, 1'b0, 4'b0100, "mid_ptr2");
    arst = 1'b1;
    step(4'b1111, 1'b0, 4'b0001, "async_reset");
    step(4'b1111, 1'b1, 4'b0001, "reset_beats_update");
    arst = 1'b0;
    step(4'b0010, 1'b1, 4'b0010, "post_reset0");
    step(4'b0001, 1'b1, 4'b0001, "post_reset1");
    step(4'b1111, 1'b0, 4'b0010, "post_reset_ptr1");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
